// File: rtl/store_drain_unit_if.sv
// store_drain_unit_if
//   Bundles the three buses around the store drain unit: the store-buffer head
//   (sb_*, store_success, busy), the data-cache tag/write/fill port (cache_*),
//   and the line-refill memory port (mem_*).
//
//   modport master : the drain unit. It consumes the store head, drives the
//                    cache and memory requests, and receives hit/grant/refill
//                    data.
//   modport slave  : the surrounding environment (store buffer, cache, memory).
//
//   Width macros WORD_SIZE, ADDRESS_WIDTH, SIZE_WRITE_WIDTH, BYTE_SIZE and
//   FULL_WORD_SIZE get local defaults when the project has not defined them.
//   The optional STORE_DRAIN_PERF_EN counters are plain module ports and are
//   not carried on this interface.

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef SIZE_WRITE_WIDTH
`define SIZE_WRITE_WIDTH 2
`endif
`ifndef BYTE_SIZE
`define BYTE_SIZE 2'b00
`endif
`ifndef FULL_WORD_SIZE
`define FULL_WORD_SIZE 2'b10
`endif

interface store_drain_unit_if #(
    parameter int WORD_SIZE        = `WORD_SIZE,
    parameter int WIDTH            = `ADDRESS_WIDTH,
    parameter int SIZE_WRITE_WIDTH = `SIZE_WRITE_WIDTH,
    parameter int LINE_SIZE        = 128
);
    // store buffer head
    logic                        sb_wenable;
    logic [WIDTH-1:0]            sb_address;
    logic [WORD_SIZE-1:0]        sb_value;
    logic [SIZE_WRITE_WIDTH-1:0] sb_size;
    logic                        store_success;
    logic                        busy;

    // data cache
    logic [WIDTH-1:0]            cache_lookup_addr;
    logic                        cache_hit;
    logic                        cache_wr_en;
    logic [WIDTH-1:0]            cache_wr_addr;
    logic [WORD_SIZE-1:0]        cache_wr_data;
    logic [WORD_SIZE/8-1:0]      cache_wr_mask;
    logic                        cache_fill_en;
    logic [WIDTH-1:0]            cache_fill_addr;
    logic [LINE_SIZE-1:0]        cache_fill_line;

    // memory refill
    logic                        mem_req;
    logic [WIDTH-1:0]            mem_addr;
    logic                        mem_grant;
    logic                        mem_rvalid;
    logic [LINE_SIZE-1:0]        mem_rdata;

    modport master (
        input  sb_wenable, sb_address, sb_value, sb_size,
        output store_success, busy,
        output cache_lookup_addr,
        input  cache_hit,
        output cache_wr_en, cache_wr_addr, cache_wr_data, cache_wr_mask,
        output cache_fill_en, cache_fill_addr, cache_fill_line,
        output mem_req, mem_addr,
        input  mem_grant, mem_rvalid, mem_rdata
    );

    modport slave (
        output sb_wenable, sb_address, sb_value, sb_size,
        input  store_success, busy,
        input  cache_lookup_addr,
        output cache_hit,
        input  cache_wr_en, cache_wr_addr, cache_wr_data, cache_wr_mask,
        input  cache_fill_en, cache_fill_addr, cache_fill_line,
        input  mem_req, mem_addr,
        output mem_grant, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/store_drain_unit.sv
// store_drain_unit
//   Drains the store buffer head into the data cache: tag lookup, byte-lane
//   masking and write-allocate line refill on a miss. A one-cycle
//   store_success pulse retires the head entry.
//
// Ports
//   clk          clock
//   reset        asynchronous, active-low reset
//   bus          store_drain_unit_if.master (store head, cache, memory)
//   perf_hits    hit counter    (only with STORE_DRAIN_PERF_EN)
//   perf_misses  miss counter   (only with STORE_DRAIN_PERF_EN)
//
// Optional feature macro: STORE_DRAIN_PERF_EN adds the saturating
// perf_hits/perf_misses counters and the CNT_WIDTH parameter.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for a valid store head; latches it when present
// LOOKUP    | latched address on the tag port, branch on cache_hit
// MISS_REQ  | holding the line read request until granted
// MISS_WAIT | waiting for refill data; captures it on mem_rvalid
// FILL      | one-cycle line install of the captured refill data
// WRITE     | one-cycle masked word write plus store_success

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef SIZE_WRITE_WIDTH
`define SIZE_WRITE_WIDTH 2
`endif
`ifndef BYTE_SIZE
`define BYTE_SIZE 2'b00
`endif
`ifndef FULL_WORD_SIZE
`define FULL_WORD_SIZE 2'b10
`endif

module store_drain_unit #(
    parameter int WORD_SIZE        = `WORD_SIZE,
    parameter int WIDTH            = `ADDRESS_WIDTH,
    parameter int SIZE_WRITE_WIDTH = `SIZE_WRITE_WIDTH,
    parameter int LINE_SIZE        = 128
`ifdef STORE_DRAIN_PERF_EN
    ,
    parameter int CNT_WIDTH        = 16
`endif
) (
    input  logic               clk,
    input  logic               reset,
    store_drain_unit_if.master bus
`ifdef STORE_DRAIN_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0] perf_hits,
    output logic [CNT_WIDTH-1:0] perf_misses
`endif
);

    localparam int LANES     = WORD_SIZE / 8;
    localparam int LANE_BITS = $clog2(LANES);
    localparam int OFF_BITS  = $clog2(LINE_SIZE / 8);

    localparam logic [WIDTH-1:0] LINE_MASK = ~WIDTH'((1 << OFF_BITS) - 1);
    localparam logic [WIDTH-1:0] WORD_MASK = ~WIDTH'(LANES - 1);
    localparam logic [SIZE_WRITE_WIDTH-1:0] SZ_BYTE = SIZE_WRITE_WIDTH'(`BYTE_SIZE);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        MISS_WAIT,
        FILL,
        WRITE
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]            req_addr;
    logic [WORD_SIZE-1:0]        req_value;
    logic [SIZE_WRITE_WIDTH-1:0] req_size;
    logic [LINE_SIZE-1:0]        fill_line;

    logic                        req_is_byte;
    logic [WIDTH-1:0]            line_addr;
    logic [WORD_SIZE-1:0]        lane_data;
    logic [LANES-1:0]            lane_mask;

    // Only the byte encoding narrows the write; every other size is a full word.
    assign req_is_byte = (req_size == SZ_BYTE);
    assign line_addr   = req_addr & LINE_MASK;
    assign lane_data   = req_is_byte ? {LANES{req_value[7:0]}} : req_value;
    assign lane_mask   = req_is_byte ? (LANES'(1) << req_addr[LANE_BITS-1:0]) : '1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request and refill capture. Clearing on reset drops any in-flight store;
    // the store buffer still owns the entry and will present it again.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_addr  <= '0;
            req_value <= '0;
            req_size  <= '0;
            fill_line <= '0;
        end else begin
            if (state == IDLE && bus.sb_wenable) begin
                req_addr  <= bus.sb_address;
                req_value <= bus.sb_value;
                req_size  <= bus.sb_size;
            end
            if (state == MISS_WAIT && bus.mem_rvalid) begin
                fill_line <= bus.mem_rdata;
            end
        end
    end

    // Every output is zero outside the state that owns it, so the whole
    // output bus reads zero while held in reset (state forced to IDLE).
    always_comb begin
        state_nxt             = state;
        bus.store_success     = 1'b0;
        bus.busy              = (state != IDLE);
        bus.cache_lookup_addr = '0;
        bus.cache_wr_en       = 1'b0;
        bus.cache_wr_addr     = '0;
        bus.cache_wr_data     = '0;
        bus.cache_wr_mask     = '0;
        bus.cache_fill_en     = 1'b0;
        bus.cache_fill_addr   = '0;
        bus.cache_fill_line   = '0;
        bus.mem_req           = 1'b0;
        bus.mem_addr          = '0;

        case (state)
            IDLE: begin
                if (bus.sb_wenable) begin
                    state_nxt = LOOKUP;
                end
            end
            LOOKUP: begin
                bus.cache_lookup_addr = req_addr;
                state_nxt = bus.cache_hit ? WRITE : MISS_REQ;
            end
            MISS_REQ: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = line_addr;
                if (bus.mem_grant) begin
                    state_nxt = MISS_WAIT;
                end
            end
            MISS_WAIT: begin
                if (bus.mem_rvalid) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                // The installed line is known to hold the target word, so the
                // write goes straight out without a second tag check.
                bus.cache_fill_en   = 1'b1;
                bus.cache_fill_addr = line_addr;
                bus.cache_fill_line = fill_line;
                state_nxt = WRITE;
            end
            WRITE: begin
                bus.cache_wr_en   = 1'b1;
                bus.cache_wr_addr = req_addr & WORD_MASK;
                bus.cache_wr_data = lane_data;
                bus.cache_wr_mask = lane_mask;
                // Retire and return to IDLE on the same edge the store buffer
                // advances, so the next IDLE sample sees the new head.
                bus.store_success = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef STORE_DRAIN_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_hits   <= '0;
            perf_misses <= '0;
        end else if (state == LOOKUP) begin
            if (bus.cache_hit) begin
                if (perf_hits != '1) begin
                    perf_hits <= perf_hits + 1'b1;
                end
            end else begin
                if (perf_misses != '1) begin
                    perf_misses <= perf_misses + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_store_drain_unit.sv
`timescale 1ns/1ps

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef SIZE_WRITE_WIDTH
`define SIZE_WRITE_WIDTH 2
`endif
`ifndef BYTE_SIZE
`define BYTE_SIZE 2'b00
`endif
`ifndef FULL_WORD_SIZE
`define FULL_WORD_SIZE 2'b10
`endif

module tb_store_drain_unit;

    localparam int WS = 32;
    localparam int AW = 32;
    localparam int SW = `SIZE_WRITE_WIDTH;
    localparam int LS = 128;

    localparam logic [SW-1:0] SZ_B = SW'(`BYTE_SIZE);
    localparam logic [SW-1:0] SZ_W = SW'(`FULL_WORD_SIZE);

    localparam logic [LS-1:0] LINE_A = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [LS-1:0] LINE_B = 128'hFEEDFACE_00112233_44556677_8899AABB;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [WS-1:0] data;
        logic [3:0]    mask;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    store_drain_unit_if #(.WORD_SIZE(WS), .WIDTH(AW), .SIZE_WRITE_WIDTH(SW), .LINE_SIZE(LS)) bus ();

`ifdef STORE_DRAIN_PERF_EN
    localparam int CW = 2;
    logic [CW-1:0] perf_hits;
    logic [CW-1:0] perf_misses;
    store_drain_unit #(.WORD_SIZE(WS), .WIDTH(AW), .SIZE_WRITE_WIDTH(SW), .LINE_SIZE(LS),
                       .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .perf_hits(perf_hits), .perf_misses(perf_misses));
`else
    store_drain_unit #(.WORD_SIZE(WS), .WIDTH(AW), .SIZE_WRITE_WIDTH(SW), .LINE_SIZE(LS)) dut (
        .clk(clk), .reset(reset), .bus(bus));
`endif

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int succ_cnt = 0;
    int fill_cnt = 0;
    int succ_cyc[$];
    wr_t sb_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.store_success === 1'b1) begin
            succ_cnt <= succ_cnt + 1;
            succ_cyc.push_back(cyc);
        end
        if (bus.cache_fill_en === 1'b1) fill_cnt <= fill_cnt + 1;
    end

    task automatic check(input string tag, input logic [LS-1:0] obs, input logic [LS-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic wr_t exp_write(input logic [AW-1:0] a, input logic [WS-1:0] v,
                                      input logic [SW-1:0] s);
        wr_t w;
        w.addr = {a[AW-1:2], 2'b00};
        if (s == SZ_B) begin
            case (a[1:0])
                2'd0:    w.mask = 4'b0001;
                2'd1:    w.mask = 4'b0010;
                2'd2:    w.mask = 4'b0100;
                default: w.mask = 4'b1000;
            endcase
            w.data = {v[7:0], v[7:0], v[7:0], v[7:0]};
        end else begin
            w.mask = 4'b1111;
            w.data = v;
        end
        return w;
    endfunction

    task automatic present(input logic [AW-1:0] a, input logic [WS-1:0] v, input logic [SW-1:0] s);
        bus.sb_wenable = 1'b1;
        bus.sb_address = a;
        bus.sb_value   = v;
        bus.sb_size    = s;
        sb_q.push_back(exp_write(a, v, s));
    endtask

    // Waits (bounded) for the cache write, then checks it against the scoreboard head.
    task automatic wait_write(input string tag, output int lat);
        wr_t e;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.cache_wr_en === 1'b1) break;
        end
        if (bus.cache_wr_en !== 1'b1) begin
            check({tag, "_timeout"}, LS'(bus.cache_wr_en), LS'(1));
        end else if (sb_q.size() == 0) begin
            check({tag, "_unexpected_write"}, LS'(sb_q.size()), LS'(1));
        end else begin
            e = sb_q.pop_front();
            check({tag, "_wr_addr"}, LS'(bus.cache_wr_addr), LS'(e.addr));
            check({tag, "_wr_data"}, LS'(bus.cache_wr_data), LS'(e.data));
            check({tag, "_wr_mask"}, LS'(bus.cache_wr_mask), LS'(e.mask));
            check({tag, "_success"}, LS'(bus.store_success), LS'(1));
        end
    endtask

    initial begin
        int lat;
        int s0;
        int f0;

        bus.sb_wenable = 1'b0;
        bus.sb_address = '0;
        bus.sb_value   = '0;
        bus.sb_size    = '0;
        bus.cache_hit  = 1'b0;
        bus.mem_grant  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_busy", LS'(bus.busy), LS'(0));
        check("rst_ctrl", LS'({bus.store_success, bus.cache_wr_en, bus.cache_fill_en, bus.mem_req}), LS'(0));
        check("rst_addrs", LS'({bus.cache_lookup_addr, bus.cache_wr_addr, bus.cache_fill_addr, bus.mem_addr}), LS'(0));
        check("rst_data", LS'({bus.cache_wr_data, bus.cache_wr_mask}), LS'(0));
        check("rst_line", bus.cache_fill_line, LS'(0));
        reset = 1'b1;

        // word hit
        @(posedge clk); #1;
        bus.cache_hit = 1'b1;
        present(32'h1000, 32'hDEADBEEF, SZ_W);
        wait_write("word_hit", lat);
        check("word_hit_latency", LS'(lat), LS'(3));
        bus.sb_wenable = 1'b0;
        @(negedge clk);
        check("word_hit_one_pulse", LS'(bus.store_success), LS'(0));
        check("word_hit_idle", LS'(bus.busy), LS'(0));

        // byte hit
        @(posedge clk); #1;
        present(32'h1003, 32'h000000AB, SZ_B);
        wait_write("byte_hit", lat);
        check("byte_hit_latency", LS'(lat), LS'(3));
        check("byte_hit_data_lit", LS'(bus.cache_wr_data), LS'(32'hABABABAB));
        bus.sb_wenable = 1'b0;

        // miss path: grant after 2 cycles, refill 4 cycles later
        @(posedge clk); #1;
        s0 = succ_cnt;
        bus.cache_hit = 1'b0;
        bus.mem_grant = 1'b0;
        present(32'h2014, 32'h55AA1234, SZ_W);
        @(negedge clk);
        @(negedge clk);
        check("miss_lookup_addr", LS'(bus.cache_lookup_addr), LS'(32'h2014));
        @(negedge clk);
        check("miss_req", LS'(bus.mem_req), LS'(1));
        check("miss_mem_addr", LS'(bus.mem_addr), LS'(32'h2010));
        @(negedge clk);
        check("miss_req_held", LS'(bus.mem_req), LS'(1));
        bus.mem_grant = 1'b1;
        @(posedge clk); #1;
        bus.mem_grant = 1'b0;
        @(negedge clk);
        check("miss_req_dropped", LS'(bus.mem_req), LS'(0));
        check("miss_wait_busy", LS'(bus.busy), LS'(1));
        repeat (3) @(negedge clk);
        check("miss_no_early_fill", LS'(bus.cache_fill_en), LS'(0));
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = LINE_A;
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        @(negedge clk);
        check("miss_fill_en", LS'(bus.cache_fill_en), LS'(1));
        check("miss_fill_addr", LS'(bus.cache_fill_addr), LS'(32'h2010));
        check("miss_fill_line", bus.cache_fill_line, LINE_A);
        check("miss_fill_no_success", LS'(bus.store_success), LS'(0));
        wait_write("miss", lat);
        check("miss_write_follows_fill", LS'(lat), LS'(1));
        bus.sb_wenable = 1'b0;
        repeat (2) @(negedge clk);
        check("miss_single_success", LS'(succ_cnt - s0), LS'(1));
        check("miss_idle", LS'(bus.busy), LS'(0));

        // back-to-back hits with sb_wenable held
        @(posedge clk); #1;
        s0 = succ_cnt;
        succ_cyc.delete();
        bus.cache_hit = 1'b1;
        present(32'h4000, 32'h11111111, SZ_W);
        wait_write("b2b_0", lat);
        check("b2b_0_latency", LS'(lat), LS'(3));
        present(32'h4005, 32'h00000022, SZ_B);
        wait_write("b2b_1", lat);
        check("b2b_1_latency", LS'(lat), LS'(3));
        present(32'h400A, 32'h00000033, SZ_B);
        wait_write("b2b_2", lat);
        check("b2b_2_latency", LS'(lat), LS'(3));
        bus.sb_wenable = 1'b0;
        repeat (3) @(negedge clk);
        check("b2b_success_count", LS'(succ_cnt - s0), LS'(3));
        check("b2b_pulse_list", LS'(succ_cyc.size()), LS'(3));
        if (succ_cyc.size() == 3) begin
            check("b2b_spacing_01", LS'(succ_cyc[1] - succ_cyc[0]), LS'(3));
            check("b2b_spacing_12", LS'(succ_cyc[2] - succ_cyc[1]), LS'(3));
        end

        // reset during MISS_WAIT, refill arrives afterwards
        @(posedge clk); #1;
        bus.cache_hit = 1'b0;
        bus.mem_grant = 1'b1;
        present(32'h3008, 32'hCAFEF00D, SZ_W);
        repeat (4) @(negedge clk);
        check("rmid_in_wait", LS'({bus.busy, bus.mem_req}), LS'(2'b10));
        s0 = succ_cnt;
        f0 = fill_cnt;
        reset = 1'b0;
        bus.sb_wenable = 1'b0;
        #1;
        check("rmid_async_idle", LS'(bus.busy), LS'(0));
        check("rmid_outputs_zero", LS'({bus.mem_req, bus.cache_fill_en, bus.cache_wr_en, bus.store_success}), LS'(0));
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = LINE_B;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        check("rmid_stays_idle", LS'(bus.busy), LS'(0));
        repeat (2) @(negedge clk);
        check("rmid_no_success", LS'(succ_cnt - s0), LS'(0));
        check("rmid_no_fill", LS'(fill_cnt - f0), LS'(0));
        sb_q.delete();

        // same store re-presented completes
        @(posedge clk); #1;
        present(32'h3008, 32'hCAFEF00D, SZ_W);
        repeat (4) @(negedge clk);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = LINE_B;
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        @(negedge clk);
        check("rmid_refill_line", bus.cache_fill_line, LINE_B);
        check("rmid_refill_addr", LS'(bus.cache_fill_addr), LS'(32'h3000));
        wait_write("rmid_retry", lat);
        bus.sb_wenable = 1'b0;
        bus.mem_grant  = 1'b0;
        repeat (2) @(negedge clk);
        check("rmid_retry_success", LS'(succ_cnt - s0), LS'(1));

`ifdef STORE_DRAIN_PERF_EN
        // counters were cleared by the reset above; one miss since then
        bus.cache_hit = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            present(32'h5000 + 32'(i * 4), 32'h0000_1000 + 32'(i), SZ_W);
            wait_write("perf_hit", lat);
            bus.sb_wenable = 1'b0;
        end
        @(negedge clk);
        check("perf_hits_2", LS'(perf_hits), LS'(2));
        check("perf_misses_1", LS'(perf_misses), LS'(1));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            present(32'h6000 + 32'(i * 4), 32'h0000_2000 + 32'(i), SZ_W);
            wait_write("perf_sat_hit", lat);
            bus.sb_wenable = 1'b0;
        end
        @(negedge clk);
        check("perf_hits_saturated", LS'(perf_hits), LS'(3));
        check("perf_misses_held", LS'(perf_misses), LS'(1));
`endif

        check("scoreboard_drained", LS'(sb_q.size()), LS'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/store_drain_unit.md
Name: store_drain_unit

Overview:
- Sits directly downstream of the store buffer. Consumes the buffer's head store (address, value, size, write-enable) and commits it into the data cache.
- Handles tag lookup, byte-lane masking and write-allocate line fill on a miss.
- Returns a one-cycle store_success pulse so the store buffer retires its head entry.

Parameters:
- WORD_SIZE, `WORD_SIZE (32): store data width.
- WIDTH, `ADDRESS_WIDTH (32): physical address width.
- SIZE_WRITE_WIDTH, `SIZE_WRITE_WIDTH: store size encoding width. Uses `BYTE_SIZE / `FULL_WORD_SIZE.
- LINE_SIZE, 128: cache line width in bits. Offset bits = $clog2(LINE_SIZE/8).
- CNT_WIDTH, 16: perf counter width (optional feature only).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- sb_wenable  in  1  head store valid
- sb_address  in  WIDTH  head store physical address
- sb_value  in  WORD_SIZE  head store data
- sb_size  in  SIZE_WRITE_WIDTH  head store size
- store_success  out  1  one-cycle pulse: head store committed
- busy  out  1  FSM not IDLE
- cache_lookup_addr  out  WIDTH  address presented for tag check
- cache_hit  in  1  combinational hit for cache_lookup_addr, same cycle
- cache_wr_en  out  1  word write strobe
- cache_wr_addr  out  WIDTH  word-aligned write address
- cache_wr_data  out  WORD_SIZE  lane-positioned data
- cache_wr_mask  out  WORD_SIZE/8  byte-lane enables
- cache_fill_en  out  1  line install strobe
- cache_fill_addr  out  WIDTH  line-aligned fill address
- cache_fill_line  out  LINE_SIZE  fill data
- mem_req  out  1  line read request
- mem_addr  out  WIDTH  line-aligned request address
- mem_grant  in  1  request accepted (same-cycle handshake with mem_req)
- mem_rvalid  in  1  fill data valid
- mem_rdata  in  LINE_SIZE  fill data

Behaviour:
- Reset (reset==0, async):
  - FSM goes to IDLE; latched request is cleared.
  - All outputs are 0, including addresses, data, mask and fill line.
  - An in-flight store is dropped without store_success. The store buffer keeps the entry and re-presents it after reset.
- FSM states: IDLE, LOOKUP, MISS_REQ, MISS_WAIT, FILL, WRITE.
- IDLE:
  - On sb_wenable=1, latch address, value and size; go to LOOKUP.
  - Inputs are ignored in every other state.
- LOOKUP:
  - Drive cache_lookup_addr = latched address.
  - cache_hit=1 -> WRITE.
  - cache_hit=0 -> MISS_REQ.
- MISS_REQ:
  - Hold mem_req=1 and mem_addr = address with offset bits zeroed.
  - On mem_grant=1 in the same cycle -> MISS_WAIT.
  - mem_req deasserts the cycle after grant.
- MISS_WAIT:
  - On mem_rvalid=1, capture mem_rdata -> FILL.
  - mem_rvalid seen in any other state is ignored.
- FILL:
  - One cycle of cache_fill_en=1 with cache_fill_addr (line-aligned) and the captured line -> WRITE.
  - No re-lookup.
- WRITE:
  - One cycle of cache_wr_en=1 with store_success=1 in the same cycle -> IDLE.
- Lane and data rules:
  - `FULL_WORD_SIZE: mask=all ones; data=value; address[1:0] forced to 0.
  - `BYTE_SIZE: mask = 1 << address[1:0]; data = value[7:0] replicated into every byte lane.
  - cache_wr_addr always has bits [1:0]=0.
- Latency and throughput:
  - Hit: sample at edge 0 (IDLE); WRITE and store_success in the 3rd cycle; back in IDLE at the next edge.
  - Throughput is one store per 3 cycles.
  - Miss: 5 cycles plus grant wait plus memory latency.
- Store buffer handoff:
  - store_success and the return to IDLE happen at the same edge as the store buffer's head advance.
  - The next sample in IDLE therefore sees the new head, so no store is double-committed.
  - sb_wenable=0 in IDLE keeps the block idle; busy=0.

Optional Feature:
- Macro: STORE_DRAIN_PERF_EN.
- Defined: adds outputs perf_hits and perf_misses, each CNT_WIDTH bits.
  - perf_hits increments on each LOOKUP with hit; perf_misses on each LOOKUP with miss.
  - Both saturate at all ones and reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Word hit: sb_address=0x1000, value=0xDEADBEEF, size=`FULL_WORD_SIZE, cache_hit=1 -> 3rd cycle shows cache_wr_en=1, addr 0x1000, mask 4'b1111, data 0xDEADBEEF, store_success=1 for exactly 1 cycle.
- Byte hit: addr 0x1003, value 0x000000AB, `BYTE_SIZE -> mask 4'b1000, data 0xABABABAB, wr_addr 0x1000.
- Miss path: addr 0x2014, cache_hit=0, grant after 2 cycles, rvalid 4 cycles later with line 0x0123...CDEF:
  - mem_addr=0x2010.
  - FILL shows cache_fill_line equal to the returned data.
  - WRITE follows immediately; a single store_success.
- Back-to-back: sb_wenable held 1 with three different hit stores -> three store_success pulses 3 cycles apart, each with the correct address; no duplicate.
- Reset mid-miss: assert reset low in MISS_WAIT; then raise rvalid -> no store_success or fill. After release, the same store re-presented completes normally.
- Perf counters (STORE_DRAIN_PERF_EN defined): 2 hits and 1 miss -> perf_hits=2, perf_misses=1. With CNT_WIDTH=2, 5 hits -> perf_hits stays 3.
